// File: rtl/generic_fir.sv
// Fixed-coefficient direct-form FIR: delay line, registered products, registered sum.
// Status flags travel in a two-stage pipeline alongside the data so they align with o_result.
module generic_fir #(
   parameter int NTAPS = 8,
   parameter int IW    = 12,
   parameter int CW    = 16,
   parameter int OW    = IW + CW + $clog2(NTAPS),
   parameter logic [NTAPS*CW-1:0] COEFFS = {16'sd1, 16'sd2, 16'sd3, 16'sd4,
                                             16'sd4, 16'sd3, 16'sd2, 16'sd1}
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_ce,
   input  logic signed [IW-1:0] i_sample,
   output logic signed [OW-1:0] o_result,
   output logic                 o_valid_first,
   output logic                 o_valid_result
);

   localparam int PW   = IW + CW;
   localparam int CNTW = $clog2(NTAPS + 1);
   localparam logic [CNTW-1:0] FULL = CNTW'(NTAPS);

   logic signed [IW-1:0] x         [NTAPS];
   logic signed [PW-1:0] prod      [NTAPS];
   logic signed [PW-1:0] prod_next [NTAPS];
   logic signed [OW-1:0] sum_next;
   logic [CNTW-1:0]      cnt;
   logic                 x_first, x_full;
   logic                 p_first, p_full;

   always_comb begin
      for (int unsigned k = 0; k < NTAPS; k++) begin
         prod_next[k] = PW'(x[k]) * PW'($signed(COEFFS[k*CW +: CW]));
      end
   end

   always_comb begin
      sum_next = '0;
      for (int unsigned k = 0; k < NTAPS; k++) begin
         sum_next = sum_next + OW'(prod[k]);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned k = 0; k < NTAPS; k++) begin
            x[k]    <= '0;
            prod[k] <= '0;
         end
         o_result <= '0;
      end else if (i_ce) begin
         x[0] <= i_sample;
         for (int unsigned k = 1; k < NTAPS; k++) begin
            x[k] <= x[k-1];
         end
         for (int unsigned k = 0; k < NTAPS; k++) begin
            prod[k] <= prod_next[k];
         end
         o_result <= sum_next;
      end
   end

   // Flags are tagged at capture time (stage 0) and then follow the products and sum.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt            <= '0;
         x_first        <= 1'b0;
         x_full         <= 1'b0;
         p_first        <= 1'b0;
         p_full         <= 1'b0;
         o_valid_first  <= 1'b0;
         o_valid_result <= 1'b0;
      end else if (i_ce) begin
         if (cnt != FULL) begin
            cnt <= cnt + CNTW'(1);
         end
         x_first        <= (cnt == '0);
         x_full         <= (cnt >= FULL - CNTW'(1));
         p_first        <= x_first;
         p_full         <= x_full;
         o_valid_first  <= p_first;
         o_valid_result <= p_full;
      end
   end

endmodule

// File: tb/tb_generic_fir.sv
// Directed bench for generic_fir: reset, impulse, step, full-scale, stall and mid-stream reset.
module tb_generic_fir;

   localparam int OW = 31;

   logic                 clk;
   logic                 rst_n;
   logic                 ce;
   logic signed [11:0]   sample;
   logic signed [11:0]   sample2;
   logic signed [OW-1:0] result;
   logic signed [OW-1:0] result2;
   logic                 vf, vr, vf2, vr2;

   int passed = 0;
   int total  = 0;

   int imp_exp  [12] = '{0, 0, 1, 2, 3, 4, 4, 3, 2, 1, 0, 0};
   int step_exp [12] = '{0, 0, 100, 300, 600, 1000, 1400, 1700, 1900, 2000, 2000, 2000};

   generic_fir dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_ce           (ce),
      .i_sample       (sample),
      .o_result       (result),
      .o_valid_first  (vf),
      .o_valid_result (vr)
   );

   generic_fir #(
      .NTAPS  (8),
      .IW     (12),
      .CW     (16),
      .COEFFS ({8{16'sh8000}})
   ) dut_fs (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_ce           (ce),
      .i_sample       (sample2),
      .o_result       (result2),
      .o_valid_first  (vf2),
      .o_valid_result (vr2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      ce    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n   = 1'b1;
      ce      = 1'b0;
      sample  = '0;
      sample2 = '0;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (result !== '0 || vf !== 1'b0 || vr !== 1'b0) begin
         $display("FAIL reset_outputs: got result=%0d vf=%b vr=%b, want 0 0 0", result, vf, vr);
      end else passed++;
      total++;
      if (result2 !== '0 || vf2 !== 1'b0 || vr2 !== 1'b0) begin
         $display("FAIL reset_outputs_fs: got result=%0d vf=%b vr=%b, want 0 0 0", result2, vf2, vr2);
      end else passed++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_impulse();
      logic signed [OW-1:0] e;
      do_reset();
      ce = 1'b1;
      for (int i = 0; i < 12; i++) begin
         sample = (i == 0) ? 12'sd1 : 12'sd0;
         @(posedge clk);
         #1;
         e = imp_exp[i];
         total++;
         if (result !== e || vf !== (i == 2) || vr !== (i >= 9)) begin
            $display("FAIL impulse[%0d]: got result=%0d vf=%b vr=%b, want %0d %b %b",
                     i, result, vf, vr, e, (i == 2), (i >= 9));
         end else passed++;
      end
   endtask

   task automatic test_step();
      logic signed [OW-1:0] e;
      do_reset();
      ce = 1'b1;
      sample = 12'sd100;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         e = step_exp[i];
         total++;
         if (result !== e || vf !== (i == 2) || vr !== (i >= 9)) begin
            $display("FAIL step[%0d]: got result=%0d vf=%b vr=%b, want %0d %b %b",
                     i, result, vf, vr, e, (i == 2), (i >= 9));
         end else passed++;
      end
   endtask

   task automatic test_full_scale();
      logic signed [OW-1:0] e;
      do_reset();
      ce = 1'b1;
      sample2 = -12'sd2048;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (i < 2)      e = '0;
         else if (i < 9) e = (i - 1) * 67108864;
         else            e = 536870912;
         total++;
         if (result2 !== e || vf2 !== (i == 2) || vr2 !== (i >= 9)) begin
            $display("FAIL full_scale[%0d]: got result=%0d vf=%b vr=%b, want %0d %b %b",
                     i, result2, vf2, vr2, e, (i == 2), (i >= 9));
         end else passed++;
      end
      sample2 = '0;
   endtask

   task automatic test_stall();
      logic signed [OW-1:0] e;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         ce = 1'b1;
         sample = (i == 0) ? 12'sd1 : 12'sd0;
         @(posedge clk);
         #1;
         e = imp_exp[i];
         total++;
         if (result !== e || vf !== (i == 2) || vr !== (i >= 9)) begin
            $display("FAIL stall_run[%0d]: got result=%0d vf=%b vr=%b, want %0d %b %b",
                     i, result, vf, vr, e, (i == 2), (i >= 9));
         end else passed++;
         ce = 1'b0;
         sample = 12'sd77;
         @(posedge clk);
         #1;
         total++;
         if (result !== e || vf !== (i == 2) || vr !== (i >= 9)) begin
            $display("FAIL stall_hold[%0d]: got result=%0d vf=%b vr=%b, want %0d %b %b",
                     i, result, vf, vr, e, (i == 2), (i >= 9));
         end else passed++;
      end
   endtask

   task automatic test_async_reset();
      logic signed [OW-1:0] e;
      do_reset();
      ce = 1'b1;
      sample = 12'sd100;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         e = step_exp[i];
         total++;
         if (result !== e) begin
            $display("FAIL pre_reset[%0d]: got result=%0d, want %0d", i, result, e);
         end else passed++;
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (result !== '0 || vf !== 1'b0 || vr !== 1'b0) begin
         $display("FAIL async_reset: got result=%0d vf=%b vr=%b, want 0 0 0", result, vf, vr);
      end else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         e = step_exp[i];
         total++;
         if (result !== e || vf !== (i == 2) || vr !== (i >= 9)) begin
            $display("FAIL post_reset[%0d]: got result=%0d vf=%b vr=%b, want %0d %b %b",
                     i, result, vf, vr, e, (i == 2), (i >= 9));
         end else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_step();
      test_full_scale();
      test_stall();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
